// File: rtl/mem_writeback_stage.sv
// Memory-access / write-back stage: drives the register-file write port and
// runs a req/ack data-memory access with a timeout, stalling upstream meanwhile.
module mem_writeback_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_valid,
  input  logic [31:0]       ip_alu_result,
  input  logic [31:0]       ip_store_data,
  input  logic [4:0]        ip_dest_reg,
  input  logic              ip_RegWrite,
  input  logic              ip_MemRead,
  input  logic              ip_MemWrite,
  input  logic              ip_MemtoReg,
  output logic              op_mem_req,
  output logic              op_mem_we,
  output logic [ADDR_W-1:0] op_mem_addr,
  output logic [31:0]       op_mem_wdata,
  input  logic              ip_mem_ack,
  input  logic [31:0]       ip_mem_rdata,
  output logic [4:0]        op_write_reg_addr,
  output logic [31:0]       op_write_data,
  output logic              op_RegWrite,
  output logic              op_stall,
  output logic              op_mem_error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [4:0]       lat_dest;
  logic             lat_regwrite;
  logic             lat_memtoreg;
  logic [31:0]      lat_alu;

  logic mem_op_c;
  logic issue_c;
  logic ack_c;
  logic timeout_c;

  // Access events; ack takes priority over timeout in the same cycle
  always_comb begin
    mem_op_c  = ip_MemRead | ip_MemWrite;
    issue_c   = (state == IDLE) && ip_valid && mem_op_c;
    ack_c     = (state == BUSY) && ip_mem_ack;
    timeout_c = (state == BUSY) && !ip_mem_ack && (count == LAST_CNT);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_c) state_nxt = BUSY;
      BUSY:    if (ack_c || timeout_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall releases on the ack or timeout cycle so upstream advances on that edge
  always_comb begin
    op_stall = 1'b0;
    case (state)
      IDLE:    op_stall = ip_valid && mem_op_c;
      BUSY:    op_stall = !ip_mem_ack && (count != LAST_CNT);
      default: op_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count             <= '0;
      lat_dest          <= '0;
      lat_regwrite      <= 1'b0;
      lat_memtoreg      <= 1'b0;
      lat_alu           <= '0;
      op_mem_req        <= 1'b0;
      op_mem_we         <= 1'b0;
      op_mem_addr       <= '0;
      op_mem_wdata      <= '0;
      op_write_reg_addr <= '0;
      op_write_data     <= '0;
      op_RegWrite       <= 1'b0;
      op_mem_error      <= 1'b0;
    end else begin
      op_RegWrite <= 1'b0;

      if (issue_c) begin
        lat_dest     <= ip_dest_reg;
        lat_regwrite <= ip_RegWrite;
        lat_memtoreg <= ip_MemtoReg;
        lat_alu      <= ip_alu_result;
        op_mem_we    <= ip_MemWrite;
        op_mem_addr  <= ip_alu_result[ADDR_W+1:2];
        op_mem_wdata <= ip_store_data;
        op_mem_req   <= 1'b1;
        count        <= '0;
      end else if (state == BUSY) begin
        if (ack_c || timeout_c) begin
          op_mem_req <= 1'b0;
          count      <= '0;
        end else begin
          count <= count + CNT_W'(1);
        end
      end

      // Non-memory instruction: one-cycle write-back of the ALU result
      if ((state == IDLE) && ip_valid && !mem_op_c) begin
        op_RegWrite       <= ip_RegWrite && (ip_dest_reg != 5'd0);
        op_write_reg_addr <= ip_dest_reg;
        op_write_data     <= ip_alu_result;
      end

      if (ack_c && !op_mem_we) begin
        op_RegWrite       <= lat_regwrite && (lat_dest != 5'd0);
        op_write_reg_addr <= lat_dest;
        op_write_data     <= lat_memtoreg ? ip_mem_rdata : lat_alu;
      end

      if (timeout_c) op_mem_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Bench for mem_writeback_stage: directed cases then random transactions,
// checked against a transaction-level expectation of the stage's behaviour.
module tb_mem_writeback_stage;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              reset;
  logic              ip_valid;
  logic [31:0]       ip_alu_result;
  logic [31:0]       ip_store_data;
  logic [4:0]        ip_dest_reg;
  logic              ip_RegWrite;
  logic              ip_MemRead;
  logic              ip_MemWrite;
  logic              ip_MemtoReg;
  logic              op_mem_req;
  logic              op_mem_we;
  logic [ADDR_W-1:0] op_mem_addr;
  logic [31:0]       op_mem_wdata;
  logic              ip_mem_ack;
  logic [31:0]       ip_mem_rdata;
  logic [4:0]        op_write_reg_addr;
  logic [31:0]       op_write_data;
  logic              op_RegWrite;
  logic              op_stall;
  logic              op_mem_error;

  mem_writeback_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock             (clock),
    .reset             (reset),
    .ip_valid          (ip_valid),
    .ip_alu_result     (ip_alu_result),
    .ip_store_data     (ip_store_data),
    .ip_dest_reg       (ip_dest_reg),
    .ip_RegWrite       (ip_RegWrite),
    .ip_MemRead        (ip_MemRead),
    .ip_MemWrite       (ip_MemWrite),
    .ip_MemtoReg       (ip_MemtoReg),
    .op_mem_req        (op_mem_req),
    .op_mem_we         (op_mem_we),
    .op_mem_addr       (op_mem_addr),
    .op_mem_wdata      (op_mem_wdata),
    .ip_mem_ack        (ip_mem_ack),
    .ip_mem_rdata      (ip_mem_rdata),
    .op_write_reg_addr (op_write_reg_addr),
    .op_write_data     (op_write_data),
    .op_RegWrite       (op_RegWrite),
    .op_stall          (op_stall),
    .op_mem_error      (op_mem_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Expected sticky/held state of the stage
  logic              m_err;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [31:0]       m_wdata;
  int                stall_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic mtr,
                       input logic rw, input logic [4:0] dest, input logic [31:0] alu,
                       input logic [31:0] sd);
    ip_valid      = v;
    ip_MemRead    = rd;
    ip_MemWrite   = wr;
    ip_MemtoReg   = mtr;
    ip_RegWrite   = rw;
    ip_dest_reg   = dest;
    ip_alu_result = alu;
    ip_store_data = sd;
  endtask

  task automatic idle_cycle(input logic ack_noise);
    drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom), $urandom, $urandom);
    ip_mem_ack   = ack_noise;
    ip_mem_rdata = $urandom;
    @(negedge clock);
    chk("idle_stall", 32'(op_stall), 32'(0));
    @(posedge clock); #1;
    ip_mem_ack = 1'b0;
    chk("idle_regwrite", 32'(op_RegWrite), 32'(0));
    chk("idle_req", 32'(op_mem_req), 32'(0));
    chk("idle_err", 32'(op_mem_error), 32'(m_err));
  endtask

  task automatic alu_op(input logic [4:0] dest, input logic rw, input logic [31:0] alu,
                        input logic ack_noise);
    drive(1'b1, 1'b0, 1'b0, 1'($urandom), rw, dest, alu, $urandom);
    ip_mem_ack   = ack_noise;
    ip_mem_rdata = $urandom;
    @(negedge clock);
    chk("alu_stall", 32'(op_stall), 32'(0));
    @(posedge clock); #1;
    ip_mem_ack = 1'b0;
    chk("alu_regwrite", 32'(op_RegWrite), 32'(rw && dest != 5'd0));
    chk("alu_waddr", 32'(op_write_reg_addr), 32'(dest));
    chk("alu_wdata", op_write_data, alu);
    chk("alu_req", 32'(op_mem_req), 32'(0));
    chk("alu_err", 32'(op_mem_error), 32'(m_err));
    chk("alu_maddr_held", 32'(op_mem_addr), 32'(m_addr));
  endtask

  // ack_at: BUSY cycle (1-based) carrying the ack; 0 means never acked
  task automatic mem_op(input logic rd, input logic wr, input logic [4:0] dest,
                        input logic rw, input logic mtr, input logic [31:0] alu,
                        input logic [31:0] sd, input int ack_at, input logic [31:0] rdata);
    logic acked;
    logic tout;
    logic done;
    logic exp_rw;
    int   k;
    drive(1'b1, rd, wr, mtr, rw, dest, alu, sd);
    ip_mem_ack   = 1'b0;
    ip_mem_rdata = $urandom;
    m_we    = wr;
    m_addr  = ADDR_W'(alu >> 2);
    m_wdata = sd;
    stall_cycles = 0;
    @(negedge clock);
    chk("issue_stall", 32'(op_stall), 32'(1));
    if (op_stall) stall_cycles++;
    @(posedge clock); #1;
    k     = 1;
    done  = 1'b0;
    acked = 1'b0;
    while (!done) begin
      chk("busy_req", 32'(op_mem_req), 32'(1));
      chk("busy_we", 32'(op_mem_we), 32'(m_we));
      chk("busy_addr", 32'(op_mem_addr), 32'(m_addr));
      chk("busy_wdata", op_mem_wdata, m_wdata);
      chk("busy_regwrite", 32'(op_RegWrite), 32'(0));
      // Upstream inputs change freely while the access is pending
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), $urandom, $urandom);
      acked = (k == ack_at);
      tout  = (k == int'(TIMEOUT));
      ip_mem_ack   = acked;
      ip_mem_rdata = acked ? rdata : $urandom;
      @(negedge clock);
      chk("busy_stall", 32'(op_stall), 32'(!(acked || tout)));
      if (op_stall) stall_cycles++;
      @(posedge clock); #1;
      ip_mem_ack = 1'b0;
      done = acked || tout;
      k++;
    end
    if (!acked) m_err = 1'b1;
    exp_rw = acked && !wr && rw && (dest != 5'd0);
    chk("done_req", 32'(op_mem_req), 32'(0));
    chk("done_regwrite", 32'(op_RegWrite), 32'(exp_rw));
    chk("done_err", 32'(op_mem_error), 32'(m_err));
    if (exp_rw) begin
      chk("done_waddr", 32'(op_write_reg_addr), 32'(dest));
      chk("done_wdata", op_write_data, mtr ? rdata : alu);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(op_mem_req), 32'(0));
    chk({tag, "_we"}, 32'(op_mem_we), 32'(0));
    chk({tag, "_maddr"}, 32'(op_mem_addr), 32'(0));
    chk({tag, "_mwdata"}, op_mem_wdata, 32'(0));
    chk({tag, "_regwrite"}, 32'(op_RegWrite), 32'(0));
    chk({tag, "_waddr"}, 32'(op_write_reg_addr), 32'(0));
    chk({tag, "_wdata"}, op_write_data, 32'(0));
    chk({tag, "_err"}, 32'(op_mem_error), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ip_mem_ack = 1'b0;
    ip_mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    m_err = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Directed cases
    alu_op(5'd5, 1'b1, 32'h1234, 1'b0);
    mem_op(1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    chk("load_stall_cycles", 32'(stall_cycles), 32'(3));
    mem_op(1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h8, 32'hA5A5A5A5, 1, 32'h0);
    mem_op(1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 32'h1C, 32'h0, 2, 32'h5555AAAA);
    idle_cycle(1'b1);
    alu_op(5'd0, 1'b1, 32'h77, 1'b0);
    mem_op(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'h44, 32'h0, 2, 32'hCAFEF00D);
    mem_op(1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 32'h80, 32'h0, 0, 32'h0);
    chk("timeout_stall_cycles", 32'(stall_cycles), 32'(TIMEOUT));
    alu_op(5'd6, 1'b1, 32'h9999, 1'b1);
    mem_op(1'b1, 1'b0, 5'd13, 1'b1, 1'b1, 32'h84, 32'h0, int'(TIMEOUT), 32'h13579BDF);

    // Reset in the middle of an access, then a stray ack
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    m_err = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
    chk_all_zero("midreset");
    idle_cycle(1'b1);
    chk("late_ack_waddr", 32'(op_write_reg_addr), 32'(0));
    chk("late_ack_wdata", op_write_data, 32'(0));

    // Random transactions
    for (int n = 0; n < 60; n++) begin
      int          kind;
      int          sel;
      int          ack_at;
      logic [4:0]  dest;
      kind = int'($urandom_range(0, 3));
      dest = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      sel  = int'($urandom_range(0, 9));
      ack_at = (sel == 0) ? 0 : (sel == 1) ? int'(TIMEOUT) : int'($urandom_range(1, 6));
      case (kind)
        0: alu_op(dest, 1'($urandom), $urandom, 1'($urandom));
        1: mem_op(1'b1, 1'b0, dest, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  ack_at, $urandom);
        2: mem_op(1'($urandom), 1'b1, dest, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  ack_at, $urandom);
        default: idle_cycle(1'($urandom));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
